mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory between two requesters:
//  - port C: the multicycle ARM core.
//  - port D: a DMA/program loader.
//  Serialises accesses through a small FSM and holds the memory bus stable for
//  the memory latency. Returns read data and a one-cycle ack to the owner.
//  Raises core_stall so the controller freezes its state while the core waits.
//  Sits between arm (Adr/WriteData/MemWrite/ReadData) and the memory.
// PARAMETERS
//  AW         32  address width
//  DW         32  data width
//  MEM_LAT    1   extra memory wait cycles before read data is valid (0..15)
//  STARVE_MAX 4   consecutive core grants while D waits before D is forced (1..15)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  c_req       in   1   core request; hold with c_we/c_adr/c_wd until c_ack
//  c_we        in   1   core write enable
//  c_adr       in   AW  core address
//  c_wd        in   DW  core write data
//  c_rd        out  DW  core read data, registered
//  c_ack       out  1   core transaction complete (1-cycle pulse)
//  core_stall  out  1   c_req & ~c_ack
//  d_req/d_we  in   1   loader request / write enable (same rules as port C)
//  d_adr       in   AW  loader address
//  d_wd        in   DW  loader write data
//  d_rd        out  DW  loader read data, registered
//  d_ack       out  1   loader transaction complete (1-cycle pulse)
//  mem_we      out  1   memory write enable
//  mem_adr     out  AW  memory address
//  mem_wd      out  DW  memory write data
//  mem_rd      in   DW  memory read data
//  owner       out  1   0 = core, 1 = loader (for visualisation)
//  state       out  2   FSM state: IDLE=0, ACCESS=1, DONE=2
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, owner=0, all outputs and counters 0.
//  Reset mid-transaction abandons it: no ack, no pending write.
//  IDLE: if any req is high, choose a winner and register its we/adr/wd onto
//    mem_*. Load wait counter with MEM_LAT. Go to ACCESS. No req: stay, mem_we=0.
//  ACCESS: mem_adr/mem_wd held constant; mem_we=1 only in the first ACCESS cycle.
//    Counter decrements each cycle; at 0 go to DONE. So ACCESS lasts MEM_LAT+1 cycles.
//  DONE: on a read, capture mem_rd into owner's *_rd. Pulse owner's *_ack.
//    mem_we=0. Go to IDLE.
//  *_rd holds its value until the next completed read for that port.
//  *_rd is unchanged by writes.
//  Latency: req sampled in IDLE at cycle t -> ack high in cycle t+MEM_LAT+2.
//  Back-to-back: one IDLE cycle between transactions (throughput 1 per MEM_LAT+3).
//  Req dropped after grant: transaction still completes and ack still pulses.
//  Req held high through ack: treated as a new request in the following IDLE.
//  Simultaneous requests: arbitration per CONFIGURATION.
//    A lone requester always wins.
//  Starvation counter: counts core grants made while d_req=1; cleared on any D grant.
//  core_stall is combinational from c_req and c_ack. There is no other comb path
//  from inputs to outputs.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. On a tie the port that did not own the
//    last transaction wins. Starvation counter not instantiated.
//  MEM_ARB_RR_EN undefined: fixed priority, core wins ties. After STARVE_MAX
//    consecutive core grants with d_req high, the next tie goes to D.
// TESTING
//  1 Reset: drive reset=0 mid-ACCESS on a write -> state=0, mem_we=0, no c_ack;
//    after release, IDLE with all outputs 0.
//  2 Core read, MEM_LAT=1: c_req at cycle 0, adr=0x10, mem_rd=0xDEADBEEF ->
//    mem_adr=0x10 cycle 1-2, c_ack and c_rd=0xDEADBEEF in cycle 3;
//    core_stall=1 cycles 0-2.
//  3 Loader write: d_we=1, adr=0x40, wd=0x12345678 -> mem_we=1 for exactly one
//    cycle with that adr/wd; d_ack pulses once; d_rd unchanged.
//  4 Tie, fixed priority, STARVE_MAX=4: c_req and d_req both held high ->
//    grants C,C,C,C,D,C,C,C,C,D...; owner tracks each grant.
//  5 Tie, MEM_ARB_RR_EN: both held high -> grants alternate C,D,C,D;
//    each ack goes only to its owner.
//  6 Req dropped: c_req falls the cycle after grant -> transaction completes
//    and c_ack still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified instruction/data memory between the multicycle
//   core (port C) and a DMA/program loader (port D). One transaction at a time
//   is granted in IDLE, held on the memory bus for MEM_LAT+1 ACCESS cycles, and
//   completed in DONE with a one-cycle ack (and read data) to its owner.
//
//   Build option MEM_ARB_RR_EN:
//     defined   - round-robin: on a tie the port that did not own the last
//                 transaction wins.
//     undefined - fixed priority (core wins ties); after STARVE_MAX core grants
//                 made while the loader was requesting, the next tie goes to D.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   c_req/c_we        core request / write enable, held with c_adr/c_wd to c_ack
//   c_adr, c_wd       core address / write data
//   c_rd, c_ack       core read data (registered) / completion pulse
//   core_stall        c_req & ~c_ack, the only combinational output
//   d_req/d_we        loader request / write enable (same protocol as port C)
//   d_adr, d_wd       loader address / write data
//   d_rd, d_ack       loader read data (registered) / completion pulse
//   mem_we            memory write enable, first ACCESS cycle only
//   mem_adr, mem_wd   memory address / write data, stable through ACCESS
//   mem_rd            memory read data
//   owner             0 = core, 1 = loader
//   state             IDLE=0, ACCESS=1, DONE=2

module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wd,
    output logic [DW-1:0] c_rd,
    output logic          c_ack,
    output logic          core_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wd,
    output logic [DW-1:0] d_rd,
    output logic          d_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          owner,
    output logic [1:0]    state
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] wait_q, wait_n;
    logic             owner_q, owner_n;
    logic             txn_we_q, txn_we_n;
    logic             mem_we_q, mem_we_n;
    logic [AW-1:0]    mem_adr_q, mem_adr_n;
    logic [DW-1:0]    mem_wd_q, mem_wd_n;
    logic             c_ack_q, c_ack_n;
    logic             d_ack_q, d_ack_n;
    logic [DW-1:0]    c_rd_q, c_rd_n;
    logic [DW-1:0]    d_rd_q, d_rd_n;

    logic any_req;
    logic grant;
    logic grant_d;

    assign any_req = c_req | d_req;
    assign grant   = (state_q == IDLE) && any_req;

`ifdef MEM_ARB_RR_EN
    // Last owner; starts as the loader so the core wins the first tie after reset.
    logic rr_last_q, rr_last_n;

    // Round-robin winner select and last-owner update.
    always_comb begin
        grant_d   = d_req & (~c_req | ~rr_last_q);
        rr_last_n = rr_last_q;
        if (grant) begin
            rr_last_n = grant_d;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_n;
        end
    end
`else
    // Core grants made while the loader was waiting; saturates at STARVE_MAX.
    logic [CNT_W-1:0] starve_q, starve_n;

    // Fixed priority with starvation escape for the loader.
    always_comb begin
        grant_d  = d_req & (~c_req | (starve_q >= CNT_W'(STARVE_MAX)));
        starve_n = starve_q;
        if (grant) begin
            if (grant_d) begin
                starve_n = '0;
            end else if (d_req && (starve_q < CNT_W'(STARVE_MAX))) begin
                starve_n = starve_q + CNT_W'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_n;
        end
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_n   = state_q;
        wait_n    = wait_q;
        owner_n   = owner_q;
        txn_we_n  = txn_we_q;
        mem_we_n  = 1'b0;
        mem_adr_n = mem_adr_q;
        mem_wd_n  = mem_wd_q;
        c_ack_n   = 1'b0;
        d_ack_n   = 1'b0;
        c_rd_n    = c_rd_q;
        d_rd_n    = d_rd_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_n   = ACCESS;
                    wait_n    = CNT_W'(MEM_LAT);
                    owner_n   = grant_d;
                    txn_we_n  = grant_d ? d_we  : c_we;
                    mem_we_n  = grant_d ? d_we  : c_we;
                    mem_adr_n = grant_d ? d_adr : c_adr;
                    mem_wd_n  = grant_d ? d_wd  : c_wd;
                end
            end
            ACCESS: begin
                // Ack and read data are registered on the last ACCESS edge so
                // they are visible during DONE.
                if (wait_q == '0) begin
                    state_n = DONE;
                    if (owner_q) begin
                        d_ack_n = 1'b1;
                        if (!txn_we_q) begin
                            d_rd_n = mem_rd;
                        end
                    end else begin
                        c_ack_n = 1'b1;
                        if (!txn_we_q) begin
                            c_rd_n = mem_rd;
                        end
                    end
                end else begin
                    wait_n = wait_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            owner_q   <= 1'b0;
            txn_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_wd_q  <= '0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            c_rd_q    <= '0;
            d_rd_q    <= '0;
        end else begin
            state_q   <= state_n;
            wait_q    <= wait_n;
            owner_q   <= owner_n;
            txn_we_q  <= txn_we_n;
            mem_we_q  <= mem_we_n;
            mem_adr_q <= mem_adr_n;
            mem_wd_q  <= mem_wd_n;
            c_ack_q   <= c_ack_n;
            d_ack_q   <= d_ack_n;
            c_rd_q    <= c_rd_n;
            d_rd_q    <= d_rd_n;
        end
    end

    assign state      = state_q;
    assign owner      = owner_q;
    assign mem_we     = mem_we_q;
    assign mem_adr    = mem_adr_q;
    assign mem_wd     = mem_wd_q;
    assign c_ack      = c_ack_q;
    assign d_ack      = d_ack_q;
    assign c_rd       = c_rd_q;
    assign d_rd       = d_rd_q;
    assign core_stall = c_req & ~c_ack_q;

endmodule
